// File: rtl/num_seg_scanner.sv
// Eight-digit seven-segment driver: captures a 24-bit value, converts it to BCD (or passes it
// through as hex) and scans two four-digit banks in parallel, one digit pair per SCAN_DIV cycles.
module num_seg_scanner #(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] num,
    input  logic        hex_mode,
    output logic [7:0]  seg,
    output logic [7:0]  seg1,
    output logic [7:0]  an,
    output logic        busy
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t        state, next_state;
    logic [23:0]   last_num;
    logic          last_hex;
    logic [23:0]   bin_sh;
    logic [31:0]   bcd;
    logic [4:0]    bit_cnt;
    logic          cap_hex;
    logic [31:0]   disp;
    logic          disp_hex;
    logic          changed, do_capture, do_shift, do_load;
    logic [55:0]   shifted;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [7:0]    seg_r, seg1_r, an_r;
    logic [3:0]    nib_lo, nib_hi;
    logic [2:0]    msd;
    logic          blank_lo, blank_hi;

    function automatic logic [31:0] dabble(input logic [31:0] b);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < 8; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 8'b11111100;
            4'h1: glyph = 8'b01100000;
            4'h2: glyph = 8'b11011010;
            4'h3: glyph = 8'b11110010;
            4'h4: glyph = 8'b01100110;
            4'h5: glyph = 8'b10110110;
            4'h6: glyph = 8'b10111110;
            4'h7: glyph = 8'b11100000;
            4'h8: glyph = 8'b11111110;
            4'h9: glyph = 8'b11110110;
            4'hA: glyph = 8'b11101110;
            4'hB: glyph = 8'b00111110;
            4'hC: glyph = 8'b10011100;
            4'hD: glyph = 8'b01111010;
            4'hE: glyph = 8'b10011110;
            4'hF: glyph = 8'b10001110;
            default: glyph = 8'b00000000;
        endcase
    endfunction

    assign changed = (num != last_num) || (hex_mode != last_hex);
    assign shifted = {dabble(bcd), bin_sh} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (changed) next_state = hex_mode ? LOAD : CONV;
            CONV:    if (bit_cnt == 5'd23) next_state = LOAD;
            LOAD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        do_capture = 1'b0;
        do_shift   = 1'b0;
        do_load    = 1'b0;
        case (state)
            IDLE:    do_capture = changed;
            CONV:    do_shift   = 1'b1;
            LOAD:    do_load    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_num <= '0;
            last_hex <= 1'b0;
            bin_sh   <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            cap_hex  <= 1'b0;
            disp     <= '0;
            disp_hex <= 1'b0;
            busy     <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            if (do_capture) begin
                last_num <= num;
                last_hex <= hex_mode;
                bin_sh   <= num;
                bcd      <= '0;
                bit_cnt  <= '0;
                cap_hex  <= hex_mode;
            end else if (do_shift) begin
                bcd     <= shifted[55:24];
                bin_sh  <= shifted[23:0];
                bit_cnt <= bit_cnt + 5'd1;
            end
            // Hex captures go straight to LOAD, so bin_sh still holds the unshifted value.
            if (do_load) begin
                disp     <= cap_hex ? {8'h00, bin_sh} : bcd;
                disp_hex <= cap_hex;
            end
        end
    end

    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++)
            if (disp[4*i +: 4] != 4'd0) msd = 3'(i);
    end

    assign nib_lo   = disp[{idx, 2'b00} +: 4];
    assign nib_hi   = disp[{1'b1, idx, 2'b00} +: 4];
    assign blank_lo = (BLANK_LZ && ({1'b0, idx} > msd)) || (!disp_hex && nib_lo > 4'd9);
    assign blank_hi = (BLANK_LZ && ({1'b1, idx} > msd)) || (!disp_hex && nib_hi > 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            seg_r    <= 8'h00;
            seg1_r   <= 8'h00;
            an_r     <= 8'h00;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
            seg_r  <= blank_lo ? 8'h00 : glyph(nib_lo);
            seg1_r <= blank_hi ? 8'h00 : glyph(nib_hi);
            an_r   <= 8'h11 << idx;
        end
    end

    // Enable gates the registered outputs directly so blanking takes effect without delay.
    assign seg  = enable ? seg_r  : 8'h00;
    assign seg1 = enable ? seg1_r : 8'h00;
    assign an   = enable ? an_r   : 8'h00;
endmodule

// File: tb/tb_num_seg_scanner.sv
// Bench for num_seg_scanner: two instances (leading-zero blanking on/off) share stimulus and are
// compared against an arithmetic digit/glyph model.
module tb_num_seg_scanner;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst, enable, hex_mode;
    logic [23:0] num;
    logic [7:0]  seg, seg1, an, seg_b, seg1_b, an_b;
    logic        busy, busy_b;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [23:0] v;
        bit          hx;
        int          busy_len;
        logic [7:0]  g0;
        logic [7:0]  g4;
        logic [7:0]  g7;
    } vec_t;

    vec_t        tbl [8];
    logic [7:0]  s [20];
    logic [7:0]  e_an;
    int unsigned cur_v, rv;
    bit          cur_h, rh;
    int          j, k0, kk;

    num_seg_scanner #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .num(num), .hex_mode(hex_mode),
        .seg(seg), .seg1(seg1), .an(an), .busy(busy));

    num_seg_scanner #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .enable(enable), .num(num), .hex_mode(hex_mode),
        .seg(seg_b), .seg1(seg1_b), .an(an_b), .busy(busy_b));

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
            4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
            8: return 8'hFE;  9: return 8'hF6;  10: return 8'hEE; 11: return 8'h3E;
            12: return 8'h9C; 13: return 8'h7A; 14: return 8'h9E; 15: return 8'h8E;
            default: return 8'h00;
        endcase
    endfunction

    // Digit k of v in base 10 or 16; blank when v has no digit at position k (k > 0).
    function automatic logic [7:0] model_seg(input int unsigned v, input bit hx, input int k,
                                             input bit blz);
        longint unsigned p, base;
        int d;
        base = hx ? 16 : 10;
        p = 1;
        for (int i = 0; i < k; i++) p = p * base;
        d = int'((longint'(v) / p) % base);
        if (blz && k > 0 && longint'(v) < p) return 8'h00;
        return glyph(d);
    endfunction

    function automatic int an_idx(input logic [7:0] a);
        logic [7:0] t;
        for (int i = 0; i < 4; i++) begin
            t = 8'h11 << i;
            if (a == t) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_now(input int unsigned v, input bit hx, input string tag);
        int k;
        logic [7:0] t;
        k = an_idx(an);
        if (k < 0) begin
            chk({tag, "_an"}, 64'(an), 64'h11);
            return;
        end
        t = 8'h11 << k;
        chk({tag, "_seg"},    64'(seg),    64'(model_seg(v, hx, k, 1'b1)));
        chk({tag, "_seg1"},   64'(seg1),   64'(model_seg(v, hx, k + 4, 1'b1)));
        chk({tag, "_an_nb"},  64'(an_b),   64'(t));
        chk({tag, "_seg_nb"}, 64'(seg_b),  64'(model_seg(v, hx, k, 1'b0)));
        chk({tag, "_seg1_nb"},64'(seg1_b), 64'(model_seg(v, hx, k + 4, 1'b0)));
    endtask

    task automatic check_display(input int unsigned v, input bit hx, input string tag);
        for (int i = 0; i < 4 * SD; i++) begin
            @(negedge clk);
            check_now(v, hx, tag);
        end
    endtask

    task automatic wait_done(input int exp_len, input string tag);
        int cnt;
        cnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
        chk(tag, 64'(cnt), 64'(exp_len));
    endtask

    task automatic apply(input int unsigned v, input bit hx);
        num      = v[23:0];
        hex_mode = hx;
        cur_v    = v;
        cur_h    = hx;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{24'hFFFFFF, 1'b0, 25, 8'hB6, 8'hE0, 8'h60};
        tbl[1] = '{24'h000005, 1'b0, 25, 8'hB6, 8'h00, 8'h00};
        tbl[2] = '{24'h123456, 1'b1, 1,  8'hBE, 8'hDA, 8'h00};
        tbl[3] = '{24'h00000A, 1'b1, 1,  8'hEE, 8'h00, 8'h00};
        tbl[4] = '{24'h000000, 1'b1, 1,  8'hFC, 8'h00, 8'h00};
        tbl[5] = '{24'h0F4240, 1'b0, 25, 8'hFC, 8'hFC, 8'h00};
        tbl[6] = '{24'hBC614E, 1'b0, 25, 8'hFE, 8'h66, 8'h60};
        tbl[7] = '{24'h00ABCD, 1'b1, 1,  8'h7A, 8'h00, 8'h00};

        rst = 1'b1; enable = 1'b1;
        apply(0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_outputs",    {39'd0, busy, seg, seg1, an}, 64'd0);
        chk("reset_outputs_nb", {39'd0, busy_b, seg_b, seg1_b, an_b}, 64'd0);
        rst = 1'b0;

        kk = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) kk++;
        end
        chk("zero_no_capture", 64'(kk), 64'd0);
        check_display(0, 1'b0, "zero");

        // Decimal latency: busy for 25 cycles, outputs change on the 26th.
        apply(24'hBC614E, 1'b0);
        kk = 0;
        repeat (25) begin
            @(negedge clk);
            if (busy) kk++;
        end
        chk("dec_busy25", 64'(kk), 64'd25);
        @(negedge clk);
        chk("dec_busy_low", 64'(busy), 64'd0);
        check_now(0, 1'b0, "dec_old");
        @(negedge clk);
        check_now(24'hBC614E, 1'b0, "dec_new");

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s[i] = an;
        end
        j = -1;
        for (int i = 1; i < 5; i++) if (j < 0 && s[i] != s[i-1]) j = i;
        chk("an_step_found", 64'(j > 0), 64'd1);
        if (j < 0) j = 1;
        k0 = an_idx(s[0]);
        for (int i = j; i < 20; i++)
            chk("an_step", 64'(s[i]), 64'(8'h11 << ((k0 + 1 + (i - j) / SD) % 4)));

        // Hex latency: busy for one cycle, outputs change two cycles after capture.
        apply(24'h00ABCD, 1'b1);
        @(negedge clk);
        chk("hex_busy_high", 64'(busy), 64'd1);
        @(negedge clk);
        chk("hex_busy_low", 64'(busy), 64'd0);
        check_now(24'hBC614E, 1'b0, "hex_old");
        @(negedge clk);
        check_now(24'h00ABCD, 1'b1, "hex_new");

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].v, tbl[i].hx);
            wait_done(tbl[i].busy_len, $sformatf("tbl%0d_busy", i));
            for (int c = 0; c < 4 * SD; c++) begin
                @(negedge clk);
                kk = an_idx(an);
                if (kk == 0) chk($sformatf("tbl%0d_g0", i), 64'(seg), 64'(tbl[i].g0));
                if (kk == 0) chk($sformatf("tbl%0d_g4", i), 64'(seg1), 64'(tbl[i].g4));
                if (kk == 3) chk($sformatf("tbl%0d_g7", i), 64'(seg1), 64'(tbl[i].g7));
                check_now(tbl[i].v, tbl[i].hx, $sformatf("tbl%0d", i));
            end
        end

        // New value mid-conversion is only picked up after the current one lands.
        apply(5, 1'b0);
        repeat (5) @(negedge clk);
        num = 24'hFFFFFF;
        cur_v = 24'hFFFFFF;
        wait_done(20, "midconv_first_busy");
        @(negedge clk);
        chk("midconv_recapture", 64'(busy), 64'd1);
        check_now(5, 1'b0, "midconv_shows5");
        wait_done(24, "midconv_second_busy");
        check_display(24'hFFFFFF, 1'b0, "midconv_final");

        // Reset mid-conversion clears outputs before the next edge, then restarts.
        apply(24'h0A1B2C, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async",    {39'd0, busy, seg, seg1, an}, 64'd0);
        chk("rst_async_nb", {39'd0, busy_b, seg_b, seg1_b, an_b}, 64'd0);
        @(negedge clk);
        chk("rst_hold", {39'd0, busy, seg, seg1, an}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_restart_busy", 64'(busy), 64'd1);
        check_now(0, 1'b0, "rst_no_partial");
        wait_done(24, "rst_restart_len");
        check_display(24'h0A1B2C, 1'b0, "rst_final");

        // Enable off for one full scan period; index keeps advancing underneath.
        e_an = an;
        enable = 1'b0;
        #1;
        chk("en_off_now",    {40'd0, seg, seg1, an}, 64'd0);
        chk("en_off_now_nb", {40'd0, seg_b, seg1_b, an_b}, 64'd0);
        for (int i = 0; i < 4 * SD; i++) begin
            @(negedge clk);
            chk("en_off", {16'd0, seg, seg1, an, seg_b, seg1_b, an_b}, 64'd0);
        end
        enable = 1'b1;
        #1;
        chk("en_resume_an", 64'(an), 64'(e_an));
        check_display(24'h0A1B2C, 1'b0, "en_resume");

        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 2))
                0:       rv = $urandom & 32'h00FF_FFFF;
                1:       rv = $urandom_range(0, 999);
                default: rv = $urandom_range(0, 99999);
            endcase
            rh = 1'($urandom_range(0, 1));
            if (rv == cur_v && rh == cur_h) rv = rv ^ 32'd1;
            apply(rv, rh);
            wait_done(rh ? 1 : 25, "rnd_busy");
            check_display(rv, rh, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/num_seg_scanner.md
NUM_SEG_SCANNER -- requirements
Module: num_seg_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, meaning clk cycles each digit pair stays lit; legal values are 2 or more.
REQ-002 Parameter BLANK_LZ, default 1, meaning 1 blanks leading zero digits.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = display on; 0 = all segments and anodes off.
REQ-006 num  input  24  value to display; sampled from the CPU LED outputs, zero-extended.
REQ-007 hex_mode  input  1  1 = show hexadecimal digits; 0 = show decimal digits.
REQ-008 seg  output  8  segments for digits 0-3, bit order {a,b,c,d,e,f,g,dp}, active-high.
REQ-009 seg1  output  8  segments for digits 4-7, same bit order and polarity as seg.
REQ-010 an  output  8  digit enables, active-high; an[0] is the least significant digit.
REQ-011 busy  output  1  1 while a decimal conversion is in progress.

Function
REQ-012 The capture FSM SHALL have three states: IDLE, CONV and LOAD.
REQ-013 In IDLE, when (num, hex_mode) differs from the last captured pair, the block SHALL capture both values and move to LOAD if hex_mode=1, else to CONV.
REQ-014 CONV SHALL run double-dabble on the 24-bit value for exactly 24 cycles: add 3 to every BCD nibble >= 5, then shift left one bit, for a 32-bit (8-digit) BCD result.
REQ-015 LOAD SHALL write the result into the 32-bit display register in one cycle, then return to IDLE.
REQ-016 In hex mode the display register SHALL be the captured num zero-extended to 32 bits, i.e. eight hex nibbles.
REQ-017 Latency from capture to display-register update SHALL be 26 cycles in decimal mode and 2 cycles in hex mode.
REQ-018 busy SHALL be 1 exactly in the CONV and LOAD states.
REQ-019 Changes to num during CONV or LOAD SHALL NOT affect the conversion in progress; the new value is picked up in the first IDLE cycle after it.
REQ-020 Maximum decimal input 16777215 SHALL display "16777215" with no overflow; the BCD width covers the full 24-bit range.
REQ-021 The scan counter SHALL count 0..SCAN_DIV-1 and wrap to 0; the digit index (0..3) SHALL advance on each wrap and wrap from 3 back to 0.
REQ-022 For digit index k, seg SHALL drive the glyph of digit k and seg1 the glyph of digit k+4, with only an[k] and an[k+4] high.
REQ-023 Glyph decoding SHALL cover 0-9 and A-F; dp SHALL always be 0.
REQ-024 In decimal mode any BCD nibble above 9 SHALL display blank; this cannot occur in correct operation and exists only as a safety case.
REQ-025 With BLANK_LZ=1, every digit above the most significant nonzero digit SHALL be blank (segments 0, anode still driven); digit 0 SHALL never be blanked.
REQ-026 enable=0 SHALL force seg, seg1 and an to 0 in the same cycle, while the scan counter and conversion keep running.
REQ-027 All outputs SHALL be registered, except the enable gating described in REQ-026.

Reset
REQ-028 While rst=1, the block SHALL hold state IDLE, scan counter 0, digit index 0, display register 0, last-captured pair (0,0), busy 0, and seg/seg1/an at 0.
REQ-029 rst asserted in CONV SHALL abort the conversion immediately with no partial display update.
REQ-030 On the first clk after rst falls, a nonzero num SHALL start a capture.

Verification
REQ-031 Scenario: SCAN_DIV=4, num=0x00BC614E, hex_mode=0 -> busy high for 25 cycles; display reads "12345678"; an steps 0x11,0x22,0x44,0x88 every 4 cycles.
REQ-032 Scenario: hex_mode=1, num=0x00ABCD -> 2 cycles later digits 0-3 show D,C,B,A; digits 4-7 are blank with BLANK_LZ=1 and show "0" with BLANK_LZ=0.
REQ-033 Scenario: num=0, decimal mode -> only digit 0 shows "0" (seg=8'b11111100 while an=0x11); seg1 stays 0.
REQ-034 Scenario: num changes from 5 to 16777215 mid-CONV -> display shows "5" first, then "16777215" 26 cycles after the next IDLE.
REQ-035 Scenario: rst pulsed mid-CONV -> all outputs 0 and busy 0 asynchronously, before the next clk edge; after release, conversion restarts from the current num.
REQ-036 Scenario: enable dropped during a scan -> seg, seg1 and an are 0 in the same cycle; after re-enable, scanning resumes at the digit index it had reached.
